// File: rtl/flash_ctrl_pkg.sv
// Shared types and constants for the flash read controller:
// FSM state encoding, row-field widths and default phase timings.
package flash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SENSE1  = 3'd2,
        SENSE2  = 3'd3,
        OUTEN   = 3'd4,
        CAPTURE = 3'd5
    } state_e;

    localparam int unsigned STR_W  = 1;
    localparam int unsigned WL_W   = 2;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned ROW_W  = STR_W + WL_W;
    localparam int unsigned NUM_STR = 1 << STR_W;
    localparam int unsigned NUM_WL  = 1 << WL_W;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned DEF_SETUP_CYC = 4;
    localparam int unsigned DEF_SENSE_CYC = 8;
    localparam int unsigned DEF_OUT_CYC   = 2;

endpackage

// File: rtl/flash_row_decode.sv
// Combinational row decoder: turns a latched row address into one-hot
// string-select / ground-select and word-line enables while a read is active.
module flash_row_decode
    import flash_ctrl_pkg::*;
(
    input  logic [ROW_W-1:0]   row,
    input  logic               active,
    output logic [NUM_STR-1:0] ssl_en,
    output logic [NUM_STR-1:0] gsl_en,
    output logic [NUM_WL-1:0]  wl0_en,
    output logic [NUM_WL-1:0]  wl1_en
);

    logic [STR_W-1:0] str_sel;
    logic [WL_W-1:0]  wl_sel;

    assign str_sel = row[ROW_W-1 -: STR_W];
    assign wl_sel  = row[WL_W-1:0];

    always_comb begin
        ssl_en = '0;
        gsl_en = '0;
        wl0_en = '0;
        wl1_en = '0;
        if (active) begin
            ssl_en[str_sel] = 1'b1;
            gsl_en[str_sel] = 1'b1;
            // Only the selected string's word-line group gets a driven line.
            if (str_sel == '0) begin
                wl0_en[wl_sel] = 1'b1;
            end else begin
                wl1_en[wl_sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_read_seq.sv
// Flash page read sequencer: select/settle, two-stage sense, output enable,
// then capture of the sense-amp data with a one-cycle valid pulse.
module flash_read_seq
    import flash_ctrl_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned SENSE_CYC = DEF_SENSE_CYC,
    parameter int unsigned OUT_CYC   = DEF_OUT_CYC
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             req_i,
    input  logic [2:0]       row_i,
    output logic             ready_o,
    output logic             rvalid_o,
    output logic [7:0]       rdata_o,
    output logic [1:0]       ssl_en_o,
    output logic [1:0]       gsl_en_o,
    output logic [3:0]       wl0_en_o,
    output logic [3:0]       wl1_en_o,
    output logic             sen1_o,
    output logic             sen2_o,
    output logic [3:0]       out_en_o,
    input  logic [7:0]       sa_out_i
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYC - 1);
    localparam logic [CNT_W-1:0] OUT_LD   = CNT_W'(OUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             capture;
    logic             active;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            rvalid_o <= capture;
            if (capture) begin
                rdata_o <= sa_out_i;
            end
        end
    end

    // Each phase reloads the counter with N-1 and leaves when it reaches zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        row_d    = row_q;
        capture  = 1'b0;
        ready_o  = 1'b0;
        sen1_o   = 1'b0;
        sen2_o   = 1'b0;
        out_en_o = '0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                cnt_d   = '0;
                if (req_i) begin
                    row_d   = row_i;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = SENSE_LD;
                    state_d = SENSE1;
                end
            end
            SENSE1: begin
                sen1_o = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = SENSE_LD;
                    state_d = SENSE2;
                end
            end
            SENSE2: begin
                sen1_o = 1'b1;
                sen2_o = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = OUT_LD;
                    state_d = OUTEN;
                end
            end
            OUTEN: begin
                sen1_o   = 1'b1;
                sen2_o   = 1'b1;
                out_en_o = 4'hF;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                sen1_o   = 1'b1;
                sen2_o   = 1'b1;
                out_en_o = 4'hF;
                capture  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign active = (state_q != IDLE);

    flash_row_decode u_row_decode (
        .row    (row_q),
        .active (active),
        .ssl_en (ssl_en_o),
        .gsl_en (gsl_en_o),
        .wl0_en (wl0_en_o),
        .wl1_en (wl1_en_o)
    );

endmodule

// File: tb/tb_flash_read_seq.sv
// Bench for flash_read_seq: default-timing instance plus a minimum-timing
// instance, table-driven row reads and a scoreboard of expected captures.
module tb_flash_read_seq;
    import flash_ctrl_pkg::*;

    localparam int LAT_A = 4 + 2 * 8 + 2 + 2;
    localparam int LAT_B = 1 + 2 * 1 + 1 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       req_a, ready_a, rvalid_a, sen1_a, sen2_a;
    logic [2:0] row_a;
    logic [7:0] sa_a, rdata_a;
    logic [1:0] ssl_a, gsl_a;
    logic [3:0] wl0_a, wl1_a, oe_a;

    logic       req_b, ready_b, rvalid_b, sen1_b, sen2_b;
    logic [2:0] row_b;
    logic [7:0] sa_b, rdata_b;
    logic [1:0] ssl_b, gsl_b;
    logic [3:0] wl0_b, wl1_b, oe_b;

    flash_read_seq #(.SETUP_CYC(4), .SENSE_CYC(8), .OUT_CYC(2)) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_i(req_a), .row_i(row_a),
        .ready_o(ready_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .ssl_en_o(ssl_a), .gsl_en_o(gsl_a), .wl0_en_o(wl0_a), .wl1_en_o(wl1_a),
        .sen1_o(sen1_a), .sen2_o(sen2_a), .out_en_o(oe_a), .sa_out_i(sa_a)
    );

    flash_read_seq #(.SETUP_CYC(1), .SENSE_CYC(1), .OUT_CYC(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_i(req_b), .row_i(row_b),
        .ready_o(ready_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .ssl_en_o(ssl_b), .gsl_en_o(gsl_b), .wl0_en_o(wl0_b), .wl1_en_o(wl1_b),
        .sen1_o(sen1_b), .sen2_o(sen2_b), .out_en_o(oe_b), .sa_out_i(sa_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [2:0] row;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   pulses_a = 0, pulses_b = 0;
    int   map_viol = 0, ord_viol = 0;
    int   ph_setup = 0, ph_s1 = 0, ph_s2 = 0, ph_oe = 0;

    // Scoreboard / protocol monitor for the default-timing instance.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] x_sel;
        logic [3:0] x_wl0, x_wl1;
        if (!rst_n) begin
            q_a.delete();
            ph_setup = 0; ph_s1 = 0; ph_s2 = 0; ph_oe = 0;
        end else begin
            if (ready_a && req_a) begin
                e.data = sa_a; e.row = row_a; e.cyc = cyc;
                q_a.push_back(e);
            end
            if (rvalid_a) begin
                pulses_a++;
                if (q_a.size() == 0) begin
                    check("rvalid_a_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check("rdata_a", {24'd0, rdata_a}, {24'd0, e.data});
                    check("latency_a", cyc - e.cyc, LAT_A);
                    check("setup_cycles_a", ph_setup, 4);
                    check("sense1_cycles_a", ph_s1, 8);
                    check("sense2_cycles_a", ph_s2, 8);
                    check("outen_capture_cycles_a", ph_oe, 3);
                end
                ph_setup = 0; ph_s1 = 0; ph_s2 = 0; ph_oe = 0;
            end
            if (!ready_a) begin
                if (!sen1_a) ph_setup++;
                else if (!sen2_a) ph_s1++;
                else if (oe_a == 4'h0) ph_s2++;
                else ph_oe++;
                if (q_a.size() == 0) begin
                    map_viol++;
                end else begin
                    x_sel = q_a[0].row[2] ? 2'b10 : 2'b01;
                    x_wl0 = q_a[0].row[2] ? 4'b0000 : (4'b0001 << q_a[0].row[1:0]);
                    x_wl1 = q_a[0].row[2] ? (4'b0001 << q_a[0].row[1:0]) : 4'b0000;
                    if (ssl_a !== x_sel || gsl_a !== x_sel || wl0_a !== x_wl0 || wl1_a !== x_wl1)
                        map_viol++;
                end
            end else if ({ssl_a, gsl_a, wl0_a, wl1_a, sen1_a, sen2_a, oe_a} != '0) begin
                map_viol++;
            end
            if ((sen2_a && !sen1_a) || (oe_a != 4'h0 && !sen2_a)) ord_viol++;
            if ((sen2_b && !sen1_b) || (oe_b != 4'h0 && !sen2_b)) ord_viol++;
        end
    end

    // Scoreboard for the minimum-timing instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q_b.delete();
        end else begin
            if (ready_b && req_b) begin
                e.data = sa_b; e.row = row_b; e.cyc = cyc;
                q_b.push_back(e);
            end
            if (rvalid_b) begin
                pulses_b++;
                if (q_b.size() == 0) begin
                    check("rvalid_b_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check("rdata_b", {24'd0, rdata_b}, {24'd0, e.data});
                    check("latency_b", cyc - e.cyc, LAT_B);
                end
            end
        end
    end

    // sel: 0 rvalid_a, 1 SENSE1 of A, 2 SENSE2 of A, 3 rvalid_b
    task automatic wait_for(input int sel, input string name);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            case (sel)
                0: hit = rvalid_a;
                1: hit = sen1_a && !sen2_a;
                2: hit = sen2_a && (oe_a == 4'h0);
                default: hit = rvalid_b;
            endcase
            if (hit) break;
        end
        if (!hit) check({"timeout_", name}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [2:0] row;
        logic [7:0] data;
        logic [1:0] ssl;
        logic [3:0] wl0;
        logic [3:0] wl1;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int p0;
        vecs[0] = '{3'b110, 8'hA5, 2'b10, 4'b0000, 4'b0100};
        vecs[1] = '{3'b000, 8'h11, 2'b01, 4'b0001, 4'b0000};
        vecs[2] = '{3'b001, 8'h22, 2'b01, 4'b0010, 4'b0000};
        vecs[3] = '{3'b010, 8'h44, 2'b01, 4'b0100, 4'b0000};
        vecs[4] = '{3'b011, 8'h88, 2'b01, 4'b1000, 4'b0000};
        vecs[5] = '{3'b100, 8'h5A, 2'b10, 4'b0000, 4'b0001};
        vecs[6] = '{3'b101, 8'hC3, 2'b10, 4'b0000, 4'b0010};
        vecs[7] = '{3'b110, 8'h3C, 2'b10, 4'b0000, 4'b0100};
        vecs[8] = '{3'b111, 8'hFF, 2'b10, 4'b0000, 4'b1000};

        rst_n = 1'b0;
        req_a = 1'b0; row_a = '0; sa_a = '0;
        req_b = 1'b0; row_b = '0; sa_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("reset_rdata", {24'd0, rdata_a}, 32'd0);
        check("reset_enables", {ssl_a, gsl_a, wl0_a, wl1_a, sen1_a, sen2_a, oe_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, ready_a}, 32'd1);

        // Table-driven single reads across every row.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            row_a = vecs[i].row; sa_a = vecs[i].data; req_a = 1'b1;
            @(posedge clk);
            #1;
            req_a = 1'b0;
            check("ready_busy", {31'd0, ready_a}, 32'd0);
            wait_for(1, "sense1");
            check("ssl_en", {30'd0, ssl_a}, {30'd0, vecs[i].ssl});
            check("gsl_en", {30'd0, gsl_a}, {30'd0, vecs[i].ssl});
            check("wl_en", {24'd0, wl0_a, wl1_a}, {24'd0, vecs[i].wl0, vecs[i].wl1});
            wait_for(0, "rvalid");
            check("rdata_table", {24'd0, rdata_a}, {24'd0, vecs[i].data});
            check("ready_with_rvalid", {31'd0, ready_a}, 32'd1);
            @(posedge clk);
            #1;
            check("rdata_hold", {24'd0, rdata_a}, {24'd0, vecs[i].data});
            check("rvalid_one_cycle", {31'd0, rvalid_a}, 32'd0);
        end

        // req_i held high: four back-to-back reads.
        p0 = pulses_a;
        @(posedge clk);
        #1;
        row_a = 3'b001; sa_a = 8'h96; req_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_for(0, "b2b_rvalid");
            if (k == 3) begin
                req_a = 1'b0;
            end else begin
                row_a = 3'(k * 3 + 4); sa_a = 8'(8'h30 + k);
            end
        end
        repeat (30) @(posedge clk);
        #1;
        check("b2b_pulses", pulses_a - p0, 4);

        // Extra request pulse during SENSE1 must be dropped.
        p0 = pulses_a;
        row_a = 3'b010; sa_a = 8'h69; req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wait_for(1, "pulse_sense1");
        row_a = 3'b111; req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("ignored_req_pulses", pulses_a - p0, 1);

        // Reset during SENSE2 aborts the read.
        p0 = pulses_a;
        row_a = 3'b101; sa_a = 8'hE7; req_a = 1'b1;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wait_for(2, "sense2");
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_enables", {ssl_a, gsl_a, wl0_a, wl1_a, sen1_a, sen2_a, oe_a}, 32'd0);
        check("abort_rdata", {24'd0, rdata_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", {31'd0, ready_a}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_rvalid", pulses_a - p0, 0);

        // Minimum timing instance: single reads then a held request.
        p0 = pulses_b;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            row_b = 3'(k + 2); sa_b = 8'($urandom_range(255)); req_b = 1'b1;
            @(posedge clk);
            #1;
            req_b = 1'b0;
            wait_for(3, "rvalid_b");
        end
        sa_b = 8'h7E; req_b = 1'b1;
        for (int k = 0; k < 3; k++) wait_for(3, "rvalid_b_b2b");
        req_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pulses_b", pulses_b - p0, 8);

        check("enable_map_violations", map_viol, 0);
        check("sense_order_violations", ord_viol, 0);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
